// File: rtl/nearest_note_searcher.sv
// Binary nearest-value search over a sorted table held in a single-port BRAM.
// Returns the closest entry, its index, the signed correction and an exact flag.
module xilinx_single_port_ram_read_first #(
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter     INIT_FILE       = ""
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);
    logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                bram[addra] <= dina;
            end
            ram_data <= bram[addra];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
        assign douta = ram_data;
    end else begin : g_high_perf
        logic [RAM_WIDTH-1:0] douta_reg;
        always_ff @(posedge clka) begin
            if (rsta) begin
                douta_reg <= '0;
            end else if (regcea) begin
                douta_reg <= ram_data;
            end
        end
        assign douta = douta_reg;
    end
endmodule

module nearest_note_searcher #(
    parameter int WIDTH        = 12,
    parameter int DEPTH        = 64,
    parameter int READ_LATENCY = 2,
    parameter     INIT_FILE    = "semitones.mem"
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     search_valid_in,
    output logic                     search_ready_out,
    input  logic [WIDTH-1:0]         search_val_in,
    output logic                     result_valid_out,
    input  logic                     result_ready_in,
    output logic [WIDTH-1:0]         closest_value_out,
    output logic [$clog2(DEPTH)-1:0] closest_index_out,
    output logic signed [WIDTH:0]    offset_out,
    output logic                     exact_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam PERF = (READ_LATENCY == 1) ? "LOW_LATENCY" : "HIGH_PERFORMANCE";

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_WAIT,
        ST_COMPARE,
        ST_RESOLVE,
        ST_DONE
    } state_t;

    state_t state_q, state_d;
    logic [LW-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [3:0] wait_q, wait_d;
    logic [WIDTH-1:0] above_val_q, above_val_d, below_val_q, below_val_d;
    logic [AW-1:0] above_idx_q, above_idx_d, below_idx_q, below_idx_d;
    logic above_vld_q, above_vld_d, below_vld_q, below_vld_d;
    logic ready_q, ready_d;
    logic res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_val_q, res_val_d;
    logic [AW-1:0] res_idx_q, res_idx_d;
    logic signed [WIDTH:0] res_off_q, res_off_d;
    logic res_exact_q, res_exact_d;

    logic [LW:0] mid_sum;
    logic [AW-1:0] mid;
    logic [AW-1:0] ram_addr;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] d_above, d_below;
    logic pick_above;
    logic [WIDTH-1:0] sel_val;
    logic [AW-1:0] sel_idx;
    logic signed [WIDTH:0] sel_off;

    assign mid_sum = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid = AW'(mid_sum >> 1);
    // RAM samples the address at the end of PROBE, so present mid directly then.
    assign ram_addr = (state_q == ST_PROBE) ? mid : addr_q;

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH      (WIDTH),
        .RAM_DEPTH      (DEPTH),
        .RAM_PERFORMANCE(PERF),
        .INIT_FILE      (INIT_FILE)
    ) u_ram (
        .addra  (ram_addr),
        .dina   ('0),
        .clka   (clk_in),
        .wea    (1'b0),
        .ena    (1'b1),
        .rsta   (~rst_n_in),
        .regcea (1'b1),
        .douta  (rdata)
    );

    // Ties resolve toward the lower entry.
    always_comb begin
        d_above = above_val_q - val_q;
        d_below = val_q - below_val_q;
        pick_above = above_vld_q && (!below_vld_q || (d_above < d_below));
        sel_val = pick_above ? above_val_q : below_val_q;
        sel_idx = pick_above ? above_idx_q : below_idx_q;
        sel_off = $signed({1'b0, sel_val}) - $signed({1'b0, val_q});
    end

    always_comb begin
        state_d = state_q;
        lo_d = lo_q;
        hi_d = hi_q;
        addr_d = addr_q;
        val_d = val_q;
        wait_d = wait_q;
        above_val_d = above_val_q;
        above_idx_d = above_idx_q;
        above_vld_d = above_vld_q;
        below_val_d = below_val_q;
        below_idx_d = below_idx_q;
        below_vld_d = below_vld_q;
        ready_d = 1'b0;
        res_valid_d = res_valid_q;
        res_val_d = res_val_q;
        res_idx_d = res_idx_q;
        res_off_d = res_off_q;
        res_exact_d = res_exact_q;
        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (ready_q && search_valid_in) begin
                    val_d = search_val_in;
                    lo_d = '0;
                    hi_d = LW'(DEPTH);
                    above_vld_d = 1'b0;
                    below_vld_d = 1'b0;
                    ready_d = 1'b0;
                    state_d = ST_PROBE;
                end
            end
            ST_PROBE: begin
                addr_d = mid;
                if (READ_LATENCY > 1) begin
                    wait_d = 4'(READ_LATENCY - 2);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_COMPARE;
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_COMPARE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_COMPARE: begin
                if (rdata >= val_q) begin
                    hi_d = {1'b0, addr_q};
                    above_val_d = rdata;
                    above_idx_d = addr_q;
                    above_vld_d = 1'b1;
                end else begin
                    lo_d = {1'b0, addr_q} + LW'(1);
                    below_val_d = rdata;
                    below_idx_d = addr_q;
                    below_vld_d = 1'b1;
                end
                state_d = (lo_d == hi_d) ? ST_RESOLVE : ST_PROBE;
            end
            ST_RESOLVE: begin
                res_val_d = sel_val;
                res_idx_d = sel_idx;
                res_off_d = sel_off;
                res_exact_d = (sel_off == '0);
                res_valid_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (result_ready_in) begin
                    res_valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            lo_q <= '0;
            hi_q <= '0;
            addr_q <= '0;
            val_q <= '0;
            wait_q <= '0;
            above_val_q <= '0;
            above_idx_q <= '0;
            above_vld_q <= 1'b0;
            below_val_q <= '0;
            below_idx_q <= '0;
            below_vld_q <= 1'b0;
            ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_val_q <= '0;
            res_idx_q <= '0;
            res_off_q <= '0;
            res_exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q <= lo_d;
            hi_q <= hi_d;
            addr_q <= addr_d;
            val_q <= val_d;
            wait_q <= wait_d;
            above_val_q <= above_val_d;
            above_idx_q <= above_idx_d;
            above_vld_q <= above_vld_d;
            below_val_q <= below_val_d;
            below_idx_q <= below_idx_d;
            below_vld_q <= below_vld_d;
            ready_q <= ready_d;
            res_valid_q <= res_valid_d;
            res_val_q <= res_val_d;
            res_idx_q <= res_idx_d;
            res_off_q <= res_off_d;
            res_exact_q <= res_exact_d;
        end
    end

    assign search_ready_out = ready_q;
    assign result_valid_out = res_valid_q;
    assign closest_value_out = res_val_q;
    assign closest_index_out = res_idx_q;
    assign offset_out = res_off_q;
    assign exact_out = res_exact_q;
endmodule

// File: tb/tb_nearest_note_searcher.sv
// Directed bench for nearest_note_searcher; table entry i = 100 + 10*i.
// The table is preloaded into the BRAM array before reset releases.
module tb_nearest_note_searcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic search_valid = 1'b0;
    logic search_ready;
    logic [11:0] search_val = '0;
    logic result_valid;
    logic result_ready = 1'b0;
    logic [11:0] closest_value;
    logic [5:0] closest_index;
    logic signed [12:0] offset;
    logic exact;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nearest_note_searcher #(
        .WIDTH(12),
        .DEPTH(64),
        .READ_LATENCY(2),
        .INIT_FILE("semitones.mem")
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .search_valid_in(search_valid),
        .search_ready_out(search_ready),
        .search_val_in(search_val),
        .result_valid_out(result_valid),
        .result_ready_in(result_ready),
        .closest_value_out(closest_value),
        .closest_index_out(closest_index),
        .offset_out(offset),
        .exact_out(exact)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue a request and return cycles from the accepting edge to result_valid.
    task automatic launch(input logic [11:0] v, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!search_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!search_ready) chk("ready_timeout", 0, 1);
        search_valid = 1'b1;
        search_val = v;
        @(posedge clk);
        #1;
        search_valid = 1'b0;
        search_val = 12'hABC;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!result_valid && n < 60);
        if (!result_valid) begin
            chk("result_timeout", 0, 1);
            lat = -1;
        end else begin
            lat = n;
        end
    endtask

    task automatic check_result(input string tag, input int ev, input int ei,
                                input int eo, input int ee);
        @(negedge clk);
        chk({tag, "_valid"}, int'(result_valid), 1);
        chk({tag, "_value"}, int'(closest_value), ev);
        chk({tag, "_index"}, int'(closest_index), ei);
        chk({tag, "_offset"}, int'(offset), eo);
        chk({tag, "_exact"}, int'(exact), ee);
        chk({tag, "_busy"}, int'(search_ready), 0);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk({tag, "_drop"}, int'(result_valid), 0);
    endtask

    typedef struct {
        string tag;
        int v;
        int ev;
        int ei;
        int eo;
        int ee;
        int lat;
    } vec_t;

    vec_t vecs[7];
    int lat;
    logic [11:0] h_val;
    logic [5:0] h_idx;
    logic signed [12:0] h_off;
    int seen;

    initial begin
        for (int i = 0; i < 64; i++) dut.u_ram.bram[i] = 12'(100 + 10 * i);

        vecs[0] = '{"hit100", 100, 100, 0, 0, 1, -1};
        vecs[1] = '{"hit730", 730, 730, 63, 0, 1, -1};
        vecs[2] = '{"near104", 104, 100, 0, -4, 0, -1};
        vecs[3] = '{"near106", 106, 110, 1, 4, 0, -1};
        vecs[4] = '{"tie105", 105, 100, 0, -5, 0, -1};
        vecs[5] = '{"below50", 50, 100, 0, 50, 0, 22};
        vecs[6] = '{"above4000", 4000, 730, 63, -3270, 0, 19};

        #3;
        chk("rst_ready", int'(search_ready), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_value", int'(closest_value), 0);
        chk("rst_offset", int'(offset), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_pre", int'(search_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_ready_post", int'(search_ready), 1);

        foreach (vecs[k]) begin
            launch(12'(vecs[k].v), lat);
            if (vecs[k].lat >= 0) chk({vecs[k].tag, "_lat"}, lat, vecs[k].lat);
            check_result(vecs[k].tag, vecs[k].ev, vecs[k].ei, vecs[k].eo, vecs[k].ee);
            handshake(vecs[k].tag);
        end

        // Backpressure: 300 is entry 20.
        launch(12'd300, lat);
        check_result("bp", 300, 20, 0, 1);
        h_val = closest_value;
        h_idx = closest_index;
        h_off = offset;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                search_valid = 1'b1;
                search_val = 12'd500;
            end
            @(negedge clk);
            search_valid = 1'b0;
            chk("bp_hold_valid", int'(result_valid), 1);
            chk("bp_hold_value", int'(closest_value), int'(h_val));
            chk("bp_hold_index", int'(closest_index), int'(h_idx));
            chk("bp_hold_offset", int'(offset), int'(h_off));
            chk("bp_hold_ready", int'(search_ready), 0);
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("bp_drop", int'(result_valid), 0);
        chk("bp_ready_after", int'(search_ready), 1);
        launch(12'd106, lat);
        check_result("bp_next", 110, 1, 4, 0);
        handshake("bp_next");

        // Reset during WAIT of the third probe.
        @(negedge clk);
        search_valid = 1'b1;
        search_val = 12'd104;
        @(posedge clk);
        #1;
        search_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", int'(search_ready), 0);
        chk("mid_rst_valid", int'(result_valid), 0);
        chk("mid_rst_value", int'(closest_value), 0);
        chk("mid_rst_index", int'(closest_index), 0);
        chk("mid_rst_offset", int'(offset), 0);
        chk("mid_rst_exact", int'(exact), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready_up", int'(search_ready), 1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        chk("mid_rst_no_result", seen, 0);
        launch(12'd104, lat);
        chk("post_rst_lat", lat, 22);
        check_result("post_rst", 100, 0, -4, 0);
        handshake("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
